// File: rtl/pad_io_pkg.sv
// Shared defaults and types for the pad-to-core I/O bridge.
package pad_io_pkg;
  localparam int DEF_DATA_IN_W   = 16;
  localparam int DEF_BIDIR_W     = 4;
  localparam int DEF_DOUT_W      = 8;
  localparam int DEF_FLAG_W      = 3;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_HOLD_CYCLES = 3;
  localparam int DEF_OUT_W       = DEF_FLAG_W + DEF_DOUT_W;

  // Bit positions inside the flag field, MSB first: {carry,sign,overflow}
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_SIGN  = 1;
  localparam int FLAG_OVF   = 0;

  typedef enum logic {IDLE, HOLD} drain_state_e;

  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/pad_io_bridge_if.sv
// Pad/core signal bundle for pad_io_bridge; slave = bridge side, master = pads/core side.
interface pad_io_bridge_if #(
  parameter int DATA_IN_W  = pad_io_pkg::DEF_DATA_IN_W,
  parameter int BIDIR_W    = pad_io_pkg::DEF_BIDIR_W,
  parameter int DOUT_W     = pad_io_pkg::DEF_DOUT_W,
  parameter int FLAG_W     = pad_io_pkg::DEF_FLAG_W,
  parameter int FIFO_DEPTH = pad_io_pkg::DEF_FIFO_DEPTH
) ();
  localparam int LVL_W = pad_io_pkg::level_w(FIFO_DEPTH);

  logic [DATA_IN_W-1:0]         pad_data_in;
  logic [BIDIR_W-1:0]           bidir_inputs_from_pad;
  logic [BIDIR_W+DATA_IN_W-1:0] cpu_data_in;
  logic                         cpu_in_changed;
  logic [DOUT_W-1:0]            cpu_data_out;
  logic [FLAG_W-1:0]            cpu_flags;
  logic                         cpu_out_valid;
  logic                         cpu_out_ready;
  logic                         drop_clr;
  logic [FLAG_W+DOUT_W-1:0]     bidir_output_data;
  logic                         pad_out_strobe;
  logic [LVL_W-1:0]             fifo_level;
  logic                         drop_sticky;

  modport slave (
    input  pad_data_in, bidir_inputs_from_pad, cpu_data_out, cpu_flags, cpu_out_valid, drop_clr,
    output cpu_data_in, cpu_in_changed, cpu_out_ready, bidir_output_data, pad_out_strobe,
           fifo_level, drop_sticky
  );
  modport master (
    output pad_data_in, bidir_inputs_from_pad, cpu_data_out, cpu_flags, cpu_out_valid, drop_clr,
    input  cpu_data_in, cpu_in_changed, cpu_out_ready, bidir_output_data, pad_out_strobe,
           fifo_level, drop_sticky
  );
endinterface

// File: rtl/pad_out_fifo.sv
// Synchronous FIFO buffering core result words; registered level, no fall-through.
module pad_out_fifo import pad_io_pkg::*; #(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int WIDTH = DEF_OUT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    cnt;
  logic             do_push, do_pop;

  assign do_pop  = pop && !empty;
  // A push on full is still taken when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign full    = (cnt == LW'(DEPTH));
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/pad_io_bridge.sv
// Pad-to-core bridge: input capture with change pulse, output word FIFO and
// a drain FSM replaying words to the pads with a strobe and hold time.
// Build option PAD_IN_SYNC_EN: adds a 2-flop synchroniser ahead of the input capture.
module pad_io_bridge import pad_io_pkg::*; #(
  parameter int DATA_IN_W   = DEF_DATA_IN_W,
  parameter int BIDIR_W     = DEF_BIDIR_W,
  parameter int DOUT_W      = DEF_DOUT_W,
  parameter int FLAG_W      = DEF_FLAG_W,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic          pad_clk,
  input  logic          pad_rst_n,
  pad_io_bridge_if.slave bus
);
  localparam int IN_W  = BIDIR_W + DATA_IN_W;
  localparam int OUT_W = FLAG_W + DOUT_W;
  localparam int LVL_W = level_w(FIFO_DEPTH);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  logic [IN_W-1:0] pad_word, cap_src, cap_q;
  logic            chg_q;

  assign pad_word = {bus.bidir_inputs_from_pad, bus.pad_data_in};

`ifdef PAD_IN_SYNC_EN
  logic [IN_W-1:0] sync1, sync2;
  // Two-stage synchroniser for asynchronous pad inputs.
  always_ff @(posedge pad_clk) begin
    if (!pad_rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pad_word;
      sync2 <= sync1;
    end
  end
  assign cap_src = sync2;
`else
  assign cap_src = pad_word;
`endif

  // Capture register; the change pulse rises together with the new value.
  always_ff @(posedge pad_clk) begin
    if (!pad_rst_n) begin
      cap_q <= '0;
      chg_q <= 1'b0;
    end else begin
      cap_q <= cap_src;
      chg_q <= (cap_src != cap_q);
    end
  end

  assign bus.cpu_data_in    = cap_q;
  assign bus.cpu_in_changed = chg_q;

  logic [OUT_W-1:0] head;
  logic             full, empty, pop;
  logic [LVL_W-1:0] level;

  pad_out_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(OUT_W)) u_fifo (
    .clk   (pad_clk),
    .rst_n (pad_rst_n),
    .push  (bus.cpu_out_valid),
    .pop   (pop),
    .wdata ({bus.cpu_flags, bus.cpu_data_out}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign bus.cpu_out_ready = !full;
  assign bus.fifo_level    = level;

  drain_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             stb_q, stb_d;

  // Drain FSM: the counter is loaded with HOLD_CYCLES so that, counting the
  // pop cycle in IDLE, strobes are HOLD_CYCLES+2 cycles apart under backlog.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    stb_d   = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        out_d   = head;
        stb_d   = 1'b1;
        cnt_d   = CNT_W'(HOLD_CYCLES);
        state_d = HOLD;
      end
      HOLD: if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - 1'b1;
      default: state_d = IDLE;
    endcase
  end

  // Drain FSM state and pad output registers; last word stays on the pads.
  always_ff @(posedge pad_clk) begin
    if (!pad_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      stb_q   <= stb_d;
    end
  end

  assign bus.bidir_output_data = out_q;
  assign bus.pad_out_strobe    = stb_q;

  logic sticky_q;
  // Drop flag: set by a push lost on full; an explicit clear takes priority.
  always_ff @(posedge pad_clk) begin
    if (!pad_rst_n)                               sticky_q <= 1'b0;
    else if (bus.drop_clr)                        sticky_q <= 1'b0;
    else if (bus.cpu_out_valid && full && !pop)   sticky_q <= 1'b1;
  end

  assign bus.drop_sticky = sticky_q;
endmodule

// File: tb/tb_pad_io_bridge.sv
// Self-checking bench for pad_io_bridge: directed vector table, hand-written
// backlog/overflow sequences and randomized traffic against a queue model.
module tb_pad_io_bridge;
  import pad_io_pkg::*;

  localparam int IN_W  = DEF_BIDIR_W + DEF_DATA_IN_W;
  localparam int OUT_W = DEF_OUT_W;
  localparam int DEPTH = DEF_FIFO_DEPTH;
`ifdef PAD_IN_SYNC_EN
  localparam int LAT = 3;
  localparam logic [IN_W-1:0] ECDI [11] = '{20'h0, 20'h0, 20'h0, 20'h0, 20'hFFFFF, 20'hFFFFF,
                                            20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'h12345, 20'h12345};
  localparam logic ECHG [11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
`else
  localparam int LAT = 1;
  localparam logic [IN_W-1:0] ECDI [11] = '{20'h0, 20'h0, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF,
                                            20'hFFFFF, 20'h12345, 20'h12345, 20'h12345, 20'h12345};
  localparam logic ECHG [11] = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pad_io_bridge_if bus ();
  pad_io_bridge dut (.pad_clk(clk), .pad_rst_n(rst_n), .bus(bus));

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: word queue plus a cooldown timer between pops,
  // and a pure delay line for the input path.
  logic [OUT_W-1:0] mq[$];
  logic [IN_W-1:0]  hist[$];
  int               timer;
  logic [IN_W-1:0]  m_cdi;
  logic             m_chg, m_stb, m_sticky;
  logic [OUT_W-1:0] m_out;

  task automatic model_reset();
    mq.delete(); hist.delete();
    for (int i = 0; i < LAT - 1; i++) hist.push_back('0);
    timer = 0; m_cdi = '0; m_chg = 0; m_stb = 0; m_sticky = 0; m_out = '0;
  endtask

  task automatic model_edge();
    logic [IN_W-1:0] v;
    bit full, pop;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hist.push_back({bus.bidir_inputs_from_pad, bus.pad_data_in});
    v = hist.pop_front();
    m_chg = (v != m_cdi);
    m_cdi = v;
    full = (mq.size() == DEPTH);
    pop  = (timer == 0) && (mq.size() > 0);
    if (bus.drop_clr) m_sticky = 0;
    else if (bus.cpu_out_valid && full && !pop) m_sticky = 1;
    if (pop) begin
      m_out = mq.pop_front();
      m_stb = 1;
      timer = DEF_HOLD_CYCLES + 1;
    end else begin
      m_stb = 0;
      if (timer > 0) timer--;
    end
    if (bus.cpu_out_valid && (!full || pop)) mq.push_back({bus.cpu_flags, bus.cpu_data_out});
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".cdi"},    32'(bus.cpu_data_in),       32'(m_cdi));
    chk({tag, ".chg"},    32'(bus.cpu_in_changed),    32'(m_chg));
    chk({tag, ".out"},    32'(bus.bidir_output_data), 32'(m_out));
    chk({tag, ".stb"},    32'(bus.pad_out_strobe),    32'(m_stb));
    chk({tag, ".lvl"},    32'(bus.fifo_level),        32'(mq.size()));
    chk({tag, ".rdy"},    32'(bus.cpu_out_ready),     32'(mq.size() < DEPTH));
    chk({tag, ".sticky"}, 32'(bus.drop_sticky),       32'(m_sticky));
  endtask

  task automatic drive(input bit r, input logic [IN_W-1:0] pad, input bit v,
                       input logic [OUT_W-1:0] w, input bit clr);
    rst_n = r;
    bus.pad_data_in = pad[DEF_DATA_IN_W-1:0];
    bus.bidir_inputs_from_pad = pad[IN_W-1:DEF_DATA_IN_W];
    bus.cpu_out_valid = v;
    {bus.cpu_flags, bus.cpu_data_out} = w;
    bus.drop_clr = clr;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  typedef struct {
    bit               rst_n;
    logic [IN_W-1:0]  pad;
    bit               valid;
    logic [OUT_W-1:0] word;
    logic [OUT_W-1:0] e_out;
    bit               e_stb;
    int               e_lvl;
  } vec_t;

  function automatic vec_t mk(bit r, logic [IN_W-1:0] p, bit v, logic [OUT_W-1:0] w,
                              logic [OUT_W-1:0] eo, bit es, int el);
    vec_t t;
    t.rst_n = r; t.pad = p; t.valid = v; t.word = w; t.e_out = eo; t.e_stb = es; t.e_lvl = el;
    return t;
  endfunction

  vec_t tbl[$];
  logic [OUT_W-1:0] wl [5];
  logic [OUT_W-1:0] got[$];
  int stb_t[$];
  logic [OUT_W-1:0] last_word;

  initial begin
    // Reset, release with pads all ones, single word 101/A5, later input step.
    tbl.push_back(mk(0, 20'hFFFFF, 0, 11'h000, 11'h000, 0, 0));
    tbl.push_back(mk(0, 20'hFFFFF, 0, 11'h000, 11'h000, 0, 0));
    tbl.push_back(mk(1, 20'hFFFFF, 0, 11'h000, 11'h000, 0, 0));
    tbl.push_back(mk(1, 20'hFFFFF, 0, 11'h000, 11'h000, 0, 0));
    tbl.push_back(mk(1, 20'hFFFFF, 1, 11'h5A5, 11'h000, 0, 1));
    tbl.push_back(mk(1, 20'hFFFFF, 0, 11'h000, 11'h5A5, 1, 0));
    tbl.push_back(mk(1, 20'hFFFFF, 0, 11'h000, 11'h5A5, 0, 0));
    tbl.push_back(mk(1, 20'h12345, 0, 11'h000, 11'h5A5, 0, 0));
    tbl.push_back(mk(1, 20'h12345, 0, 11'h000, 11'h5A5, 0, 0));
    tbl.push_back(mk(1, 20'h12345, 0, 11'h000, 11'h5A5, 0, 0));
    tbl.push_back(mk(1, 20'h12345, 0, 11'h000, 11'h5A5, 0, 0));
    model_reset();

    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].pad, tbl[i].valid, tbl[i].word, 0);
      @(posedge clk);
      model_edge();
      #1;
      chk($sformatf("tbl%0d.cdi", i), 32'(bus.cpu_data_in),       32'(ECDI[i]));
      chk($sformatf("tbl%0d.chg", i), 32'(bus.cpu_in_changed),    32'(ECHG[i]));
      chk($sformatf("tbl%0d.out", i), 32'(bus.bidir_output_data), 32'(tbl[i].e_out));
      chk($sformatf("tbl%0d.stb", i), 32'(bus.pad_out_strobe),    32'(tbl[i].e_stb));
      chk($sformatf("tbl%0d.lvl", i), 32'(bus.fifo_level),        32'(tbl[i].e_lvl));
      chk($sformatf("tbl%0d.rdy", i), 32'(bus.cpu_out_ready),     32'd1);
      chk($sformatf("tbl%0d.sticky", i), 32'(bus.drop_sticky),    32'd0);
    end

    // Backlog: one word starts draining, four more fill the FIFO behind it.
    wl = '{11'h1C3, 11'h2F0, 11'h05A, 11'h7FF, 11'h300};
    for (int i = 0; i < 5; i++) begin
      drive(1, 20'h12345, 1, wl[i], 0);
      tick("backlog_fill");
    end
    chk("backlog_level", 32'(bus.fifo_level), 32'd4);
    chk("backlog_ready", 32'(bus.cpu_out_ready), 32'd0);
    drive(1, 20'h12345, 0, '0, 0);
    for (int c = 0; c < 30; c++) begin
      tick("backlog_drain");
      if (bus.pad_out_strobe) begin
        got.push_back(bus.bidir_output_data);
        stb_t.push_back(c);
      end
    end
    chk("backlog_nstrobes", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size() && i < 4; i++)
      chk($sformatf("backlog_word%0d", i), 32'(got[i]), 32'(wl[i+1]));
    for (int i = 1; i < stb_t.size(); i++)
      chk($sformatf("backlog_gap%0d", i), 32'(stb_t[i] - stb_t[i-1]), 32'd5);
    chk("backlog_empty", 32'(bus.fifo_level), 32'd0);

    // Overflow: fill, then keep pushing through the pop slot.
    for (int i = 0; i < 5; i++) begin
      drive(1, 20'h12345, 1, 11'(11'h100 + i), 0);
      tick("ovf_fill");
    end
    drive(1, 20'h12345, 1, 11'h6E5, 0);
    tick("ovf_drop");
    chk("ovf_sticky_set", 32'(bus.drop_sticky), 32'd1);
    drive(1, 20'h12345, 1, 11'h4D6, 0);
    tick("ovf_pushpop");
    chk("full_pushpop_level", 32'(bus.fifo_level), 32'd4);
    for (int i = 0; i < 3; i++) begin
      drive(1, 20'h12345, 1, 11'(11'h0F0 + i), 0);
      tick("ovf_more");
    end
    drive(1, 20'h12345, 1, 11'h0AA, 1);
    tick("ovf_clr");
    chk("clr_wins_over_set", 32'(bus.drop_sticky), 32'd0);
    drive(1, 20'h12345, 0, '0, 0);
    last_word = '0;
    for (int c = 0; c < 25; c++) begin
      tick("ovf_drain");
      if (bus.pad_out_strobe) last_word = bus.bidir_output_data;
    end
    chk("pushpop_word_last", 32'(last_word), 32'h4D6);
    chk("sticky_stays_clear", 32'(bus.drop_sticky), 32'd0);

    // Randomized traffic, input steps, clears and occasional resets.
    begin
      logic [IN_W-1:0] pad;
      pad = '0;
      for (int c = 0; c < 800; c++) begin
        if ($urandom_range(0, 99) < 25) pad = IN_W'($urandom);
        drive($urandom_range(0, 199) != 0, pad, $urandom_range(0, 99) < 55,
              OUT_W'($urandom), $urandom_range(0, 99) < 4);
        tick("rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
